// File: rtl/spwm_gate_driver.sv
// -----------------------------------------------------------------------------
// spwm_gate_driver
//   Sinusoidal-PWM gate driver for one half-bridge leg.
//
//   The triangular carrier is registered. Its direction is tracked so that
//   peaks and valleys can be flagged. A double-buffered modulator sample is
//   compared against the registered carrier to form the PWM demand. A gate FSM
//   turns that demand into complementary high/low gate drives and inserts
//   DEAD_CYCLES clocks of both-off time around every swap.
//
// Parameters
//   DEAD_CYCLES  dead-time length in clk cycles, 1..255
//   UPDATE_MODE  0: shadow modulator applied at valleys only
//                1: shadow modulator applied at peaks and valleys
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   1 = leg active, 0 = both gates off
//   carrier       in   [15:0] triangular carrier sample, unsigned
//   modulator     in   [15:0] modulating sample, unsigned
//   mod_valid     in   one-cycle strobe, loads modulator into the pending slot
//   gate_hi       out  high-side gate, active high, registered
//   gate_lo       out  low-side gate, active high, registered
//   duty_active   out  [15:0] modulator value used for the comparison
//   peak_pulse    out  one-cycle pulse after a detected carrier peak
//   valley_pulse  out  one-cycle pulse after a detected carrier valley
//   dbg_state     out  [2:0] gate FSM state, for observation only
//
// Handshake: mod_valid is a plain one-cycle strobe with no ready. Every strobe
// is accepted and overwrites any value still pending.
// -----------------------------------------------------------------------------
module spwm_gate_driver #(
  parameter int DEAD_CYCLES = 8,
  parameter int UPDATE_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] carrier,
  input  logic [15:0] modulator,
  input  logic        mod_valid,
  output logic        gate_hi,
  output logic        gate_lo,
  output logic [15:0] duty_active,
  output logic        peak_pulse,
  output logic        valley_pulse,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_LO_ON = 3'd1,
    S_DT_LH = 3'd2,
    S_HI_ON = 3'd3,
    S_DT_HL = 3'd4
  } state_t;

  // The counter is loaded with DEAD_CYCLES-1. The exit edge happens when it
  // reads zero, so the leg spends exactly DEAD_CYCLES cycles with both gates off.
  localparam logic [7:0] DEAD_LOAD   = 8'(DEAD_CYCLES - 1);
  localparam logic       UPD_AT_PEAK = (UPDATE_MODE != 0);

  logic [15:0] r_carrier_q;
  logic        r_dir_down;
  logic        r_peak;
  logic        r_valley;
  logic [15:0] r_pending;
  logic        r_pending_full;
  logic [15:0] r_duty;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_gate_hi;
  logic        r_gate_lo;

  logic        w_peak_evt;
  logic        w_valley_evt;
  logic        w_update_evt;
  logic        w_demand;
  state_t      w_next_state;
  logic [7:0]  w_next_cnt;

  // Extreme detection compares the incoming sample against the previous one.
  // Equal samples hold the direction.
  assign w_peak_evt   = !r_dir_down && (carrier < r_carrier_q);
  assign w_valley_evt =  r_dir_down && (carrier > r_carrier_q);
  assign w_update_evt = w_valley_evt || (UPD_AT_PEAK && w_peak_evt);

  // Strict unsigned compare. A duty of 0 never demands high, and a duty of
  // 65535 drops demand only when the carrier sits at full scale.
  assign w_demand = (r_duty > r_carrier_q);

  // Carrier input stage and extreme detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carrier_q <= '0;
      r_dir_down  <= 1'b0;
      r_peak      <= 1'b0;
      r_valley    <= 1'b0;
    end else begin
      r_carrier_q <= carrier;
      r_peak      <= w_peak_evt;
      r_valley    <= w_valley_evt;
      if (w_peak_evt) begin
        r_dir_down <= 1'b1;
      end else if (w_valley_evt) begin
        r_dir_down <= 1'b0;
      end
    end
  end

  // Modulator double buffer. On an update event the older pending value is
  // applied first. A strobe in the same cycle then refills the pending slot
  // for the next event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_duty         <= '0;
    end else begin
      if (w_update_evt && r_pending_full) begin
        r_duty         <= r_pending;
        r_pending_full <= 1'b0;
      end
      if (mod_valid) begin
        r_pending      <= modulator;
        r_pending_full <= 1'b1;
      end
    end
  end

  // Gate FSM: state register, dead counter and gate registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_gate_hi <= 1'b0;
      r_gate_lo <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      // Gates are decoded from the next state so that they switch on the
      // same edge as the state change, not one cycle later.
      r_gate_hi <= (w_next_state == S_HI_ON);
      r_gate_lo <= (w_next_state == S_LO_ON);
    end
  end

  // Gate FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (!enable) begin
      // Disabling drops both gates at once. No dead time is needed because
      // nothing is being turned on.
      w_next_state = S_OFF;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_next_state = S_LO_ON;
        end
        S_LO_ON: begin
          if (w_demand) begin
            w_next_state = S_DT_LH;
            w_next_cnt   = DEAD_LOAD;
          end
        end
        S_HI_ON: begin
          if (!w_demand) begin
            w_next_state = S_DT_HL;
            w_next_cnt   = DEAD_LOAD;
          end
        end
        S_DT_LH, S_DT_HL: begin
          // At the end of dead time the leg follows the present demand. A
          // demand glitch shorter than the dead time therefore returns the leg
          // to the side it left, without a pulse on the other side.
          if (r_cnt == 8'd0) begin
            w_next_state = w_demand ? S_HI_ON : S_LO_ON;
          end else begin
            w_next_cnt = r_cnt - 8'd1;
          end
        end
        default: begin
          w_next_state = S_OFF;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  assign gate_hi      = r_gate_hi;
  assign gate_lo      = r_gate_lo;
  assign duty_active  = r_duty;
  assign peak_pulse   = r_peak;
  assign valley_pulse = r_valley;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_spwm_gate_driver.sv
// -----------------------------------------------------------------------------
// tb_spwm_gate_driver
//   Two instances share one stimulus stream:
//     u0: DEAD_CYCLES=4, UPDATE_MODE=0
//     u1: DEAD_CYCLES=3, UPDATE_MODE=1
//   A behavioural model tracks each leg as a conducting side plus a count of
//   remaining dead cycles, and it is compared with both DUTs after every clock.
//   Directed steps add fixed-value checks at the points of interest.
// -----------------------------------------------------------------------------
module tb_spwm_gate_driver;

  localparam int D0 = 4;
  localparam int D1 = 3;
  localparam int SIDE_OFF = 0;
  localparam int SIDE_LO  = 1;
  localparam int SIDE_HI  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic        mod_valid;
  logic [15:0] carrier;
  logic [15:0] modulator;

  logic [1:0]  hi;
  logic [1:0]  lo;
  logic [1:0]  pk;
  logic [1:0]  vl;
  logic [15:0] duty0;
  logic [15:0] duty1;
  logic [2:0]  st0;
  logic [2:0]  st1;

  spwm_gate_driver #(.DEAD_CYCLES(D0), .UPDATE_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .carrier(carrier),
    .modulator(modulator), .mod_valid(mod_valid), .gate_hi(hi[0]),
    .gate_lo(lo[0]), .duty_active(duty0), .peak_pulse(pk[0]),
    .valley_pulse(vl[0]), .dbg_state(st0)
  );

  spwm_gate_driver #(.DEAD_CYCLES(D1), .UPDATE_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .carrier(carrier),
    .modulator(modulator), .mod_valid(mod_valid), .gate_hi(hi[1]),
    .gate_lo(lo[1]), .duty_active(duty1), .peak_pulse(pk[1]),
    .valley_pulse(vl[1]), .dbg_state(st1)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model state ----------------
  int m_dead_len[2] = '{D0, D1};
  int m_upd_peak[2] = '{0, 1};
  int m_cq[2];
  int m_down[2];
  int m_pk[2];
  int m_vl[2];
  int m_pend[2];
  int m_pfull[2];
  int m_duty[2];
  int m_side[2];
  int m_dead[2];

  task automatic check(input string tag, input int k, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[u%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cq[k] = 0; m_down[k] = 0; m_pk[k] = 0; m_vl[k] = 0;
      m_pend[k] = 0; m_pfull[k] = 0; m_duty[k] = 0;
      m_side[k] = SIDE_OFF; m_dead[k] = 0;
    end
  endtask

  // Advance the model by one clock, using the inputs about to be sampled.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int dem;
      int c;
      int pe;
      int ve;
      c   = int'(carrier);
      dem = (m_duty[k] > m_cq[k]) ? 1 : 0;
      pe  = (m_down[k] == 0 && c < m_cq[k]) ? 1 : 0;
      ve  = (m_down[k] == 1 && c > m_cq[k]) ? 1 : 0;
      m_pk[k] = pe;
      m_vl[k] = ve;
      if (pe == 1) m_down[k] = 1;
      if (ve == 1) m_down[k] = 0;
      if ((ve == 1 || (m_upd_peak[k] == 1 && pe == 1)) && m_pfull[k] == 1) begin
        m_duty[k]  = m_pend[k];
        m_pfull[k] = 0;
      end
      if (mod_valid) begin
        m_pend[k]  = int'(modulator);
        m_pfull[k] = 1;
      end
      m_cq[k] = c;
      // leg: a conducting side, or a dead interval counting down
      if (!enable) begin
        m_side[k] = SIDE_OFF;
        m_dead[k] = 0;
      end else if (m_dead[k] > 0) begin
        m_dead[k]--;
        if (m_dead[k] == 0) m_side[k] = (dem == 1) ? SIDE_HI : SIDE_LO;
      end else if (m_side[k] == SIDE_OFF) begin
        m_side[k] = SIDE_LO;
      end else if (m_side[k] == SIDE_LO && dem == 1) begin
        m_dead[k] = m_dead_len[k];
      end else if (m_side[k] == SIDE_HI && dem == 0) begin
        m_dead[k] = m_dead_len[k];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic eh;
      logic el;
      eh = (m_side[k] == SIDE_HI && m_dead[k] == 0);
      el = (m_side[k] == SIDE_LO && m_dead[k] == 0);
      check("gate_hi", k, 16'(hi[k]), 16'(eh));
      check("gate_lo", k, 16'(lo[k]), 16'(el));
      check("overlap", k, 16'(hi[k] & lo[k]), 16'd0);
      check("duty_active", k, (k == 0) ? duty0 : duty1, 16'(m_duty[k]));
      check("peak_pulse", k, 16'(pk[k]), 16'(m_pk[k]));
      check("valley_pulse", k, 16'(vl[k]), 16'(m_vl[k]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge. Outputs are compared at the next falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input int c, input int n);
    carrier = 16'(c);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int c, input int m);
    carrier   = 16'(c);
    modulator = 16'(m);
    mod_valid = 1'b1;
    tick();
    mod_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int any_hi;
    int npk;
    int nvl;
    int c;
    int dirr;
    int step;
    int seq[7];

    rst_n = 1'b0; enable = 1'b1; mod_valid = 1'b0;
    carrier = '0; modulator = '0;
    model_reset();
    @(negedge clk);

    // reset held with the leg enabled and the carrier running
    drive(1000, 1); drive(2000, 1); drive(3000, 1);
    check("rst_gate_hi", 0, 16'(hi[0]), 16'd0);
    check("rst_gate_lo", 0, 16'(lo[0]), 16'd0);
    check("rst_duty", 0, duty0, 16'd0);

    carrier = 16'd0;
    rst_n = 1'b1;
    tick();
    tick();
    check("lo_after_release", 0, 16'(lo[0]), 16'd1);
    check("state_lo_on", 0, 16'(st0), 16'd1);

    // peak/valley sequence with a mid-ramp modulator strobe
    seq = '{10, 20, 30, 25, 15, 5, 8};
    npk = 0; nvl = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        modulator = 16'h4000;
        mod_valid = 1'b1;
      end
      drive(seq[i], 1);
      mod_valid = 1'b0;
      npk += int'(pk[0]);
      nvl += int'(vl[0]);
      if (i == 3) begin
        check("peak_after_25", 0, 16'(pk[0]), 16'd1);
        check("duty_held_um0", 0, duty0, 16'd0);
        check("duty_at_peak_um1", 1, duty1, 16'h4000);
      end
      if (i == 6) begin
        check("valley_after_8", 0, 16'(vl[0]), 16'd1);
        check("duty_at_valley_um0", 0, duty0, 16'h4000);
      end
    end
    check("peak_count", 0, 16'(npk), 16'd1);
    check("valley_count", 0, 16'(nvl), 16'd1);

    // demand glitch shorter than the dead time
    drive(16'h5000, 8);
    check("lo_before_glitch", 0, 16'(lo[0]), 16'd1);
    any_hi = 0;
    carrier = 16'h3000;
    for (int i = 0; i < 2; i++) begin tick(); any_hi |= int'(hi[0]); end
    carrier = 16'h5000;
    for (int i = 0; i < 8; i++) begin tick(); any_hi |= int'(hi[0]); end
    check("glitch_no_hi", 0, 16'(any_hi), 16'd0);
    check("glitch_state_lo", 0, 16'(st0), 16'd1);

    // load duty 0x8000, then settle with the low side on
    strobe(16'h5000, 16'h8000);
    drive(16'h4800, 1);
    drive(16'h4900, 1);
    check("duty_8000", 0, duty0, 16'h8000);
    drive(16'h8001, 10);
    check("lo_settled", 0, 16'(lo[0]), 16'd1);

    // down-ramp across the duty threshold: low side off, high side on after 4
    drive(16'h8000, 1);
    drive(16'h7FFF, 1);
    check("lo_at_cross", 0, 16'(lo[0]), 16'd1);
    drive(16'h7FFE, 1);
    check("lo_fall", 0, 16'(lo[0]), 16'd0);
    check("hi_dead", 0, 16'(hi[0]), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hi_dead_lh", 0, 16'(hi[0]), 16'd0);
    end
    tick();
    check("hi_rise", 0, 16'(hi[0]), 16'd1);
    drive(16'h7FFE, 5);

    // enable drop while the high side is on, then re-enable
    enable = 1'b0;
    tick();
    check("dis_hi", 0, 16'(hi[0]), 16'd0);
    check("dis_lo", 0, 16'(lo[0]), 16'd0);
    enable = 1'b1;
    tick();
    check("reen_lo", 0, 16'(lo[0]), 16'd1);
    tick();
    check("reen_dt_state", 0, 16'(st0), 16'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reen_hi_dead", 0, 16'(hi[0]), 16'd0);
    end
    tick();
    check("reen_hi_on", 0, 16'(hi[0]), 16'd1);

    // up-ramp mirror
    drive(16'h7FFF, 1);
    drive(16'h8000, 1);
    check("hi_at_cross", 0, 16'(hi[0]), 16'd1);
    drive(16'h8001, 1);
    check("hi_fall", 0, 16'(hi[0]), 16'd0);
    check("lo_dead", 0, 16'(lo[0]), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lo_dead_hl", 0, 16'(lo[0]), 16'd0);
    end
    tick();
    check("lo_rise", 0, 16'(lo[0]), 16'd1);

    // duty 0: low side held across a full carrier period
    strobe(16'h8001, 0);
    drive(16'h8000, 1);
    drive(16'h8001, 1);
    check("duty_zero", 0, duty0, 16'd0);
    for (int v = 0; v <= 65535 + 4095; v += 4096) begin
      drive((v > 65535) ? 65535 : v, 1);
      check("duty0_lo_up", 0, 16'(lo[0]), 16'd1);
    end
    for (int v = 61440; v >= 0; v -= 4096) begin
      drive(v, 1);
      check("duty0_lo_dn", 0, 16'(lo[0]), 16'd1);
    end

    // duty 65535 with the carrier reaching full scale
    strobe(0, 16'hFFFF);
    drive(10, 1);
    check("duty_ffff", 0, duty0, 16'hFFFF);
    for (int v = 4096; v < 65536; v += 4096) drive(v, 1);
    drive(65535, 12);
    check("full_scale_lo", 0, 16'(lo[0]), 16'd1);
    for (int v = 61440; v >= 0; v -= 4096) drive(v, 1);
    drive(0, 6);
    check("below_full_hi", 0, 16'(hi[0]), 16'd1);

    // randomized triangle carrier, strobes, enable drops, one mid-run reset
    c = 0; dirr = 1;
    for (int i = 0; i < 1500; i++) begin
      step = $urandom_range(0, 2500);
      if ($urandom_range(0, 7) == 0) step = 0;
      c = c + dirr * step;
      if (c > 65535) begin c = 65535; dirr = -1; end
      if (c < 0) begin c = 0; dirr = 1; end
      carrier   = 16'(c);
      mod_valid = ($urandom_range(0, 7) == 0);
      modulator = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if (i > 0 && i % 200 == 0) enable = 1'b1;
      if (i == 700) begin
        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_hi", 0, 16'(hi[0]), 16'd0);
        check("async_lo", 0, 16'(lo[0]), 16'd0);
        check("async_duty", 1, duty1, 16'd0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
      end
      tick();
      mod_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
